// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and constants for the gate sweep controller
package gate_sweep_pkg;
   localparam int VEC_W = 6;
   localparam int SIG_W = 16;
   localparam int CNT_W = 7;
   localparam logic [SIG_W-1:0] SIG_TAPS = 16'hB400;
   localparam logic [SIG_W-1:0] SIG_SEED_DEF = 16'hFFFF;
   typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;
endpackage

// File: rtl/gate_sweep_misr.sv
// gate_sweep_misr: 16-bit response signature register with seed load
module gate_sweep_misr
   import gate_sweep_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [1:0]       din,
   input  logic [SIG_W-1:0] seed,
   output logic [SIG_W-1:0] sig
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         sig <= '0;
      else if (load)
         sig <= seed;
      else if (en)
         sig <= {sig[SIG_W-2:0], ^(sig & SIG_TAPS)} ^ {{(SIG_W-2){1'b0}}, din};
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks all 64 input vectors through a gate, counting and signing its responses
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int               SETTLE_CYC = 1,
   parameter logic [SIG_W-1:0] SIG_SEED   = SIG_SEED_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [VEC_W-1:0] vec_o,
   input  logic [1:0]       resp_i,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] t_cnt,
   output logic [CNT_W-1:0] k_cnt,
   output logic [SIG_W-1:0] sig_o
);
   localparam logic [3:0] W_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
   state_t     state, next;
   logic [3:0] wcnt;
   logic       accept, sample;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= IDLE;
      else
         state <= next;

   always_comb begin
      next = state;
      case (state)
         IDLE:    next = (start && !abort) ? APPLY : IDLE;
         APPLY:   next = abort ? IDLE : (SETTLE_CYC == 0) ? SAMPLE : WAIT;
         WAIT:    next = abort ? IDLE : (wcnt == W_LAST) ? SAMPLE : WAIT;
         SAMPLE:  next = abort ? IDLE : (vec_o == '1) ? DONE : APPLY;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      busy   = state inside {APPLY, WAIT, SAMPLE};
      done   = state == DONE;
      accept = state == IDLE && start && !abort;
      sample = state == SAMPLE && !abort;
   end

   // an aborted SAMPLE is not counted, so results freeze at the last completed vector
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vec_o <= '0;
         wcnt  <= '0;
         t_cnt <= '0;
         k_cnt <= '0;
      end else begin
         if (state == SAMPLE && next == APPLY)
            vec_o <= vec_o + 1'b1;
         else if (accept || next == IDLE || next == DONE)
            vec_o <= '0;
         wcnt <= (state == WAIT) ? wcnt + 1'b1 : 4'd0;
         if (accept) begin
            t_cnt <= '0;
            k_cnt <= '0;
         end else if (sample) begin
            t_cnt <= t_cnt + CNT_W'(resp_i[1]);
            k_cnt <= k_cnt + CNT_W'(resp_i[0]);
         end
      end

   gate_sweep_misr u_misr (
      .clk  (clk),
      .rst_n(rst_n),
      .load (accept),
      .en   (sample),
      .din  (resp_i),
      .seed (SIG_SEED),
      .sig  (sig_o)
   );
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed scenario bench for gate_sweep_ctrl at settle lengths 1, 0 and 15
module tb_gate_sweep_ctrl;
   logic        clk = 0, rst_n = 0, start = 0, abort = 0, start0 = 0, start15 = 0, resp_mode = 0;
   logic [1:0]  resp;
   logic [5:0]  vec, vec0, vec15;
   logic        busy, done, busy0, done0, busy15, done15;
   logic [6:0]  t_cnt, k_cnt, t0, k0, t15, k15;
   logic [15:0] sig, sig0, sig15;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;
   assign resp = resp_mode ? {vec[5] & vec[4], vec[0] | vec[1]} : 2'b00;

   gate_sweep_ctrl #(.SETTLE_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec), .resp_i(resp),
      .busy(busy), .done(done), .t_cnt(t_cnt), .k_cnt(k_cnt), .sig_o(sig));
   gate_sweep_ctrl #(.SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .vec_o(vec0), .resp_i(2'b00),
      .busy(busy0), .done(done0), .t_cnt(t0), .k_cnt(k0), .sig_o(sig0));
   gate_sweep_ctrl #(.SETTLE_CYC(15)) dut15 (
      .clk(clk), .rst_n(rst_n), .start(start15), .abort(1'b0), .vec_o(vec15), .resp_i(2'b00),
      .busy(busy15), .done(done15), .t_cnt(t15), .k_cnt(k15), .sig_o(sig15));

   function automatic logic [15:0] model_sig(input int last, input bit pat);
      logic [15:0] s = 16'hFFFF;
      logic [5:0]  v;
      logic [1:0]  d;
      for (int i = 0; i <= last; i++) begin
         v = 6'(i);
         d = pat ? {v[5] & v[4], v[0] | v[1]} : 2'b00;
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {14'b0, d};
      end
      return s;
   endfunction

   task automatic pulse_start;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask

   task automatic run_sweep(input int limit, input int poke_at, input bit poke_done,
                            output int done_at, output int busy_n, output int done_n,
                            output int steps, output int order_bad);
      int prev = -1;
      done_at = 0; busy_n = 0; done_n = 0; steps = 0; order_bad = 0;
      for (int n = 1; n <= limit; n++) begin
         if (n > 1) @(negedge clk);
         start = 0;
         if (busy) begin
            busy_n++;
            if (int'(vec) != prev) begin
               if (int'(vec) != prev + 1) order_bad++;
               steps++;
               prev = int'(vec);
            end
         end
         if (done) begin
            done_n++;
            if (vec !== 6'd0) order_bad++;
            if (done_at == 0) done_at = n;
         end
         if (n == poke_at || (poke_done && done)) start = 1;
      end
      @(negedge clk) start = 0;
   endtask

   task automatic test_reset;
      #3;
      n_cmp++;
      if ({vec, busy, done, t_cnt, k_cnt, sig} !== '0) begin
         n_bad++;
         $display("FAIL reset_initial: got vec=%0d busy=%b done=%b t=%0d k=%0d sig=%h want all 0", vec, busy, done, t_cnt, k_cnt, sig);
      end
      @(negedge clk);
      @(negedge clk) rst_n = 1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || vec !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_idle: got busy=%b vec=%0d want busy=0 vec=0", busy, vec);
      end
   endtask

   task automatic test_zero_sweep;
      int da, bn, dn, st, ob;
      resp_mode = 0;
      pulse_start;
      run_sweep(200, 0, 0, da, bn, dn, st, ob);
      n_cmp++; if (da !== 193) begin n_bad++; $display("FAIL zero_done_at: got %0d want 193", da); end
      n_cmp++; if (bn !== 192) begin n_bad++; $display("FAIL zero_busy: got %0d want 192", bn); end
      n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL zero_done_pulses: got %0d want 1", dn); end
      n_cmp++; if (t_cnt !== 7'd0 || k_cnt !== 7'd0) begin n_bad++; $display("FAIL zero_counts: got t=%0d k=%0d want 0 0", t_cnt, k_cnt); end
      n_cmp++; if (sig !== model_sig(63, 0)) begin n_bad++; $display("FAIL zero_sig: got %h want %h", sig, model_sig(63, 0)); end
      n_cmp++; if (ob !== 0 || st !== 64) begin n_bad++; $display("FAIL zero_order: got steps=%0d bad=%0d want 64 0", st, ob); end
   endtask

   task automatic test_pattern_sweep;
      int da, bn, dn, st, ob;
      resp_mode = 1;
      pulse_start;
      run_sweep(200, 0, 0, da, bn, dn, st, ob);
      n_cmp++; if (t_cnt !== 7'd16) begin n_bad++; $display("FAIL pat_t_cnt: got %0d want 16", t_cnt); end
      n_cmp++; if (k_cnt !== 7'd48) begin n_bad++; $display("FAIL pat_k_cnt: got %0d want 48", k_cnt); end
      n_cmp++; if (st !== 64 || ob !== 0) begin n_bad++; $display("FAIL pat_order: got steps=%0d bad=%0d want 64 0", st, ob); end
      n_cmp++; if (sig !== model_sig(63, 1)) begin n_bad++; $display("FAIL pat_sig: got %h want %h", sig, model_sig(63, 1)); end
      n_cmp++; if (da !== 193) begin n_bad++; $display("FAIL pat_done_at: got %0d want 193", da); end
   endtask

   task automatic test_start_ignored;
      int da, bn, dn, st, ob;
      resp_mode = 0;
      pulse_start;
      run_sweep(400, 61, 1, da, bn, dn, st, ob);
      n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL ign_done_pulses: got %0d want 1", dn); end
      n_cmp++; if (bn !== 192) begin n_bad++; $display("FAIL ign_busy: got %0d want 192", bn); end
      n_cmp++; if (da !== 193 || ob !== 0) begin n_bad++; $display("FAIL ign_timing: got done_at=%0d bad=%0d want 193 0", da, ob); end
      n_cmp++; if (sig !== model_sig(63, 0)) begin n_bad++; $display("FAIL ign_sig: got %h want %h", sig, model_sig(63, 0)); end
   endtask

   task automatic test_abort;
      int stray = 0;
      resp_mode = 1;
      pulse_start;
      repeat (32) @(negedge clk);
      n_cmp++;
      if (vec !== 6'd10 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got vec=%0d busy=%b want 10 1", vec, busy); end
      abort = 1;
      @(negedge clk) abort = 0;
      n_cmp++;
      if (busy !== 1'b0 || vec !== 6'd0 || done !== 1'b0) begin
         n_bad++; $display("FAIL abort_state: got busy=%b vec=%0d done=%b want 0 0 0", busy, vec, done);
      end
      n_cmp++; if (t_cnt !== 7'd0 || k_cnt !== 7'd7) begin n_bad++; $display("FAIL abort_counts: got t=%0d k=%0d want 0 7", t_cnt, k_cnt); end
      n_cmp++; if (sig !== model_sig(9, 1)) begin n_bad++; $display("FAIL abort_sig: got %h want %h", sig, model_sig(9, 1)); end
      repeat (10) @(negedge clk) if (busy || done) stray++;
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", stray); end
      start = 1; abort = 1;
      @(negedge clk) begin start = 0; abort = 0; end
      n_cmp++;
      if (busy !== 1'b0 || k_cnt !== 7'd7 || sig !== model_sig(9, 1)) begin
         n_bad++; $display("FAIL abort_wins: got busy=%b k=%0d sig=%h want 0 7 %h", busy, k_cnt, sig, model_sig(9, 1));
      end
   endtask

   task automatic test_settle;
      int b0 = 0, b15 = 0, d0 = 0, d15 = 0;
      @(negedge clk) begin start0 = 1; start15 = 1; end
      @(negedge clk) begin start0 = 0; start15 = 0; end
      for (int n = 1; n <= 1100; n++) begin
         if (n > 1) @(negedge clk);
         if (busy0) b0++;
         if (busy15) b15++;
         if (done0 && d0 == 0) d0 = n;
         if (done15 && d15 == 0) d15 = n;
      end
      n_cmp++; if (b0 !== 128 || d0 !== 129) begin n_bad++; $display("FAIL settle0_len: got busy=%0d done_at=%0d want 128 129", b0, d0); end
      n_cmp++; if (b15 !== 1088 || d15 !== 1089) begin n_bad++; $display("FAIL settle15_len: got busy=%0d done_at=%0d want 1088 1089", b15, d15); end
      n_cmp++; if (sig0 !== model_sig(63, 0) || t0 !== 7'd0 || k0 !== 7'd0) begin n_bad++; $display("FAIL settle0_res: got sig=%h t=%0d k=%0d want %h 0 0", sig0, t0, k0, model_sig(63, 0)); end
      n_cmp++; if (sig15 !== model_sig(63, 0) || t15 !== 7'd0 || k15 !== 7'd0) begin n_bad++; $display("FAIL settle15_res: got sig=%h t=%0d k=%0d want %h 0 0", sig15, t15, k15, model_sig(63, 0)); end
   endtask

   task automatic test_reset_mid;
      resp_mode = 1;
      pulse_start;
      repeat (100) @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || k_cnt === 7'd0) begin n_bad++; $display("FAIL rmid_pre: got busy=%b k=%0d want 1 nonzero", busy, k_cnt); end
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if ({vec, busy, done, t_cnt, k_cnt, sig} !== '0) begin
         n_bad++;
         $display("FAIL rmid_async: got vec=%0d busy=%b done=%b t=%0d k=%0d sig=%h want all 0", vec, busy, done, t_cnt, k_cnt, sig);
      end
      @(negedge clk) rst_n = 1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || vec !== 6'd0 || sig !== 16'h0 || done !== 1'b0) begin
         n_bad++; $display("FAIL rmid_no_resume: got busy=%b vec=%0d sig=%h done=%b want 0 0 0000 0", busy, vec, sig, done);
      end
   endtask

   initial begin
      test_reset;
      test_zero_sweep;
      test_pattern_sweep;
      test_start_ignored;
      test_abort;
      test_settle;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
